// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a direct-mapped, write-back, write-allocate cache array.
//
// Accepts one CPU word request at a time (valid/ready), performs the array lookup,
// and on a miss writes back a dirty victim, fetches the line for read misses, then
// allocates into the array. Completion is a one-cycle cpu_resp_valid pulse.
// Saturating hit/miss/write-back statistics counters are kept.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_*               CPU request/response port
//   cc_*                cache array control (outputs) and array results (inputs)
//   mem_*               backing memory port, single-cycle mem_ready completion
//   hit_cnt, miss_cnt,
//   wb_cnt              saturating statistics counters
module cache_ctrl_fsm #(
    parameter int unsigned TAG_W   = 22,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    // CPU port
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_resp_valid,
    output logic [31:0]        cpu_rdata,
    // Cache array control
    output logic [INDEX_W-1:0] cc_index,
    output logic [TAG_W-1:0]   cc_tag,
    output logic [1:0]         cc_offset,
    output logic               cc_read_en,
    output logic               cc_write_en,
    output logic               cc_alloc_en,
    output logic               cc_cpu_write,
    output logic [31:0]        cc_cpu_wdata,
    output logic [31:0]        cc_fill_data,
    input  logic               cc_hit,
    input  logic [31:0]        cc_rdata,
    input  logic [TAG_W-1:0]   cc_tag_out,
    input  logic               cc_valid_out,
    input  logic               cc_dirty_out,
    input  logic [31:0]        cc_wb_data,
    // Backing memory port
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata,
    // Statistics
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic [CNT_W-1:0]   wb_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StFetch,
        StAllocate,
        StRespond
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         req_addr_q, req_addr_d;
    logic                req_we_q, req_we_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic [31:0]         fill_q, fill_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;

    logic                hit_inc, miss_inc, wb_inc;
    logic [31:0]         addr_sel;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;

    // In IDLE the array sees the incoming address so its registered outputs are
    // ready in LOOKUP; afterwards the latched address keeps the index stable.
    always_comb begin
        addr_sel = (state_q == StIdle) ? cpu_addr : req_addr_q;
    end

    assign req_index = req_addr_q[INDEX_W+1:2];
    assign req_tag   = req_addr_q[31 -: TAG_W];

    assign cc_index  = addr_sel[INDEX_W+1:2];
    assign cc_tag    = addr_sel[31 -: TAG_W];
    assign cc_offset = addr_sel[1:0];

    assign cpu_rdata    = rdata_q;
    assign cc_cpu_wdata = req_wdata_q;
    assign cc_fill_data = fill_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign wb_cnt       = wb_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            fill_q      <= '0;
            rdata_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            fill_q      <= fill_d;
            rdata_q     <= rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        req_we_d       = req_we_q;
        req_wdata_d    = req_wdata_q;
        fill_d         = fill_q;
        rdata_d        = rdata_q;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        wb_inc         = 1'b0;

        cpu_req_ready  = (state_q == StIdle) & ~rst;
        cpu_resp_valid = 1'b0;
        cc_read_en     = 1'b0;
        cc_write_en    = 1'b0;
        cc_alloc_en    = 1'b0;
        cc_cpu_write   = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req_valid && cpu_req_ready) begin
                    req_addr_d  = cpu_addr;
                    req_we_d    = cpu_we;
                    req_wdata_d = cpu_wdata;
                    cc_read_en  = 1'b1;
                    state_d     = StLookup;
                end
            end

            StLookup: begin
                // Response data is don't-care for writes; drive 0 for them.
                rdata_d = req_we_q ? 32'h0 : rdata_q;
                if (cc_hit) begin
                    hit_inc = 1'b1;
                    if (req_we_q) begin
                        cc_write_en = 1'b1;
                    end else begin
                        rdata_d = cc_rdata;
                    end
                    state_d = StRespond;
                end else begin
                    miss_inc = 1'b1;
                    if (cc_valid_out && cc_dirty_out) begin
                        state_d = StWriteback;
                    end else if (req_we_q) begin
                        // Full-word write-allocate overwrites the whole word.
                        state_d = StAllocate;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end

            StWriteback: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cc_tag_out, req_index, 2'b00};
                mem_wdata = cc_wb_data;
                if (mem_ready) begin
                    wb_inc  = 1'b1;
                    state_d = req_we_q ? StAllocate : StFetch;
                end
            end

            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, 2'b00};
                if (mem_ready) begin
                    fill_d  = mem_rdata;
                    rdata_d = mem_rdata;
                    state_d = StAllocate;
                end
            end

            StAllocate: begin
                cc_alloc_en  = 1'b1;
                cc_cpu_write = req_we_q;
                state_d      = StRespond;
            end

            StRespond: begin
                cpu_resp_valid = 1'b1;
                state_d        = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (hit_inc && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (miss_inc && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
        if (wb_inc && (wb_cnt_q != '1)) begin
            wb_cnt_d = wb_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
module tb_cache_ctrl_fsm;

    localparam int unsigned TAG_W   = 22;
    localparam int unsigned INDEX_W = 8;
    localparam int unsigned CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req_valid, cpu_req_ready, cpu_we;
    logic [31:0]        cpu_addr, cpu_wdata, cpu_rdata;
    logic               cpu_resp_valid;
    logic [INDEX_W-1:0] cc_index;
    logic [TAG_W-1:0]   cc_tag, cc_tag_out;
    logic [1:0]         cc_offset;
    logic               cc_read_en, cc_write_en, cc_alloc_en, cc_cpu_write;
    logic [31:0]        cc_cpu_wdata, cc_fill_data, cc_rdata, cc_wb_data;
    logic               cc_hit, cc_valid_out, cc_dirty_out;
    logic               mem_req, mem_we, mem_ready;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic [CNT_W-1:0]   hit_cnt, miss_cnt, wb_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_ctrl_fsm #(
        .TAG_W  (TAG_W),
        .INDEX_W(INDEX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata     (cpu_rdata),
        .cc_index      (cc_index),
        .cc_tag        (cc_tag),
        .cc_offset     (cc_offset),
        .cc_read_en    (cc_read_en),
        .cc_write_en   (cc_write_en),
        .cc_alloc_en   (cc_alloc_en),
        .cc_cpu_write  (cc_cpu_write),
        .cc_cpu_wdata  (cc_cpu_wdata),
        .cc_fill_data  (cc_fill_data),
        .cc_hit        (cc_hit),
        .cc_rdata      (cc_rdata),
        .cc_tag_out    (cc_tag_out),
        .cc_valid_out  (cc_valid_out),
        .cc_dirty_out  (cc_dirty_out),
        .cc_wb_data    (cc_wb_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
        .wb_cnt        (wb_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; the following edge accepts it.
    task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        #1;
    endtask

    task automatic clear_array();
        cc_hit       = 1'b0;
        cc_valid_out = 1'b0;
        cc_dirty_out = 1'b0;
        cc_tag_out   = '0;
        cc_rdata     = '0;
        cc_wb_data   = '0;
    endtask

    // Read hit: accept, LOOKUP with hit, RESPOND.
    task automatic read_hit(input logic [31:0] addr, input logic [31:0] data);
        request(1'b0, addr, 32'h0);
        cyc();
        cpu_req_valid = 1'b0;
        cc_hit        = 1'b1;
        cc_rdata      = data;
        #1;
        cyc();
        clear_array();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        mem_ready     = 1'b0;
        mem_rdata     = '0;
        clear_array();
        #1;
        check("reset_ready", {31'h0, cpu_req_ready}, 32'h0);
        check("reset_hit_cnt", {28'h0, hit_cnt}, 32'h0);
        check("reset_rdata", cpu_rdata, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'h0, cpu_req_ready}, 32'h1);

        // Cold read miss of 0x400 with an invalid victim.
        request(1'b0, 32'h0000_0400, 32'h0);
        check("rd1_read_en", {31'h0, cc_read_en}, 32'h1);
        check("rd1_tag", {10'h0, cc_tag}, 32'h1);
        cyc();                                   // LOOKUP
        cpu_req_valid = 1'b0;
        #1;
        check("rd1_lookup_ready", {31'h0, cpu_req_ready}, 32'h0);
        cyc();                                   // FETCH
        check("rd1_fetch_req", {30'h0, mem_req, mem_we}, 32'h2);
        check("rd1_fetch_addr", mem_addr, 32'h0000_0400);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        cyc();                                   // ALLOCATE
        mem_ready = 1'b0;
        #1;
        check("rd1_alloc", {30'h0, cc_alloc_en, cc_cpu_write}, 32'h2);
        check("rd1_fill", cc_fill_data, 32'hDEAD_BEEF);
        cyc();                                   // RESPOND
        check("rd1_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check("rd1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rd1_miss_cnt", {28'h0, miss_cnt}, 32'h1);
        check("rd1_wb_cnt", {28'h0, wb_cnt}, 32'h0);
        cyc();                                   // IDLE
        check("rd1_resp_one_cycle", {31'h0, cpu_resp_valid}, 32'h0);

        // Read hit: response two cycles after acceptance, no memory traffic.
        request(1'b0, 32'h0000_0400, 32'h0);
        cyc();                                   // LOOKUP (T+1)
        cpu_req_valid = 1'b0;
        cc_hit        = 1'b1;
        cc_rdata      = 32'hDEAD_BEEF;
        #1;
        check("rd2_lookup_noresp", {30'h0, cpu_resp_valid, mem_req}, 32'h0);
        cyc();                                   // RESPOND (T+2)
        clear_array();
        #1;
        check("rd2_resp", {30'h0, cpu_resp_valid, mem_req}, 32'h2);
        check("rd2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rd2_hit_cnt", {28'h0, hit_cnt}, 32'h1);
        cyc();

        // Write hit to 0x400.
        request(1'b1, 32'h0000_0400, 32'h1234_5678);
        cyc();                                   // LOOKUP
        cpu_req_valid = 1'b0;
        cc_hit        = 1'b1;
        #1;
        check("wr_hit_write_en", {29'h0, cc_write_en, cc_read_en, cc_alloc_en}, 32'h4);
        check("wr_hit_wdata", cc_cpu_wdata, 32'h1234_5678);
        cyc();                                   // RESPOND
        clear_array();
        #1;
        check("wr_hit_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check("wr_hit_rdata_zero", cpu_rdata, 32'h0);
        check("wr_hit_cnt", {28'h0, hit_cnt}, 32'h2);
        cyc();
        read_hit(32'h0000_0400, 32'h1234_5678);
        check("rd3_rdata", cpu_rdata, 32'h1234_5678);
        cyc();

        // Read miss to 0x800 evicting the dirty line of tag 1.
        request(1'b0, 32'h0000_0800, 32'h0);
        check("rd4_tag", {10'h0, cc_tag}, 32'h2);
        cyc();                                   // LOOKUP
        cpu_req_valid = 1'b0;
        cc_valid_out  = 1'b1;
        cc_dirty_out  = 1'b1;
        cc_tag_out    = 22'h1;
        cc_wb_data    = 32'h1234_5678;
        cyc();                                   // WRITEBACK, ready held low 3 cycles
        for (int i = 0; i < 3; i++) begin
            check("wb_req", {30'h0, mem_req, mem_we}, 32'h3);
            check("wb_addr", mem_addr, 32'h0000_0400);
            check("wb_wdata", mem_wdata, 32'h1234_5678);
            if (i < 2) cyc();
        end
        mem_ready = 1'b1;
        cyc();                                   // FETCH
        mem_ready = 1'b0;
        clear_array();
        #1;
        check("rd4_wb_cnt", {28'h0, wb_cnt}, 32'h1);
        check("rd4_fetch_req", {30'h0, mem_req, mem_we}, 32'h2);
        check("rd4_fetch_addr", mem_addr, 32'h0000_0800);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        cyc();                                   // ALLOCATE
        mem_ready = 1'b0;
        #1;
        check("rd4_alloc", {30'h0, cc_alloc_en, cc_cpu_write}, 32'h2);
        cyc();                                   // RESPOND
        check("rd4_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check("rd4_rdata", cpu_rdata, 32'hCAFE_F00D);
        check("rd4_miss_cnt", {28'h0, miss_cnt}, 32'h2);
        cyc();

        // Write miss to a clean line: straight to ALLOCATE.
        request(1'b1, 32'h0000_0C04, 32'hA5A5_A5A5);
        check("wm_index", {24'h0, cc_index}, 32'h1);
        cyc();                                   // LOOKUP
        cpu_req_valid = 1'b0;
        cc_valid_out  = 1'b1;
        cyc();                                   // ALLOCATE
        clear_array();
        #1;
        check("wm_no_mem", {31'h0, mem_req}, 32'h0);
        check("wm_alloc", {30'h0, cc_alloc_en, cc_cpu_write}, 32'h3);
        check("wm_wdata", cc_cpu_wdata, 32'hA5A5_A5A5);
        cyc();                                   // RESPOND
        check("wm_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check("wm_miss_cnt", {28'h0, miss_cnt}, 32'h3);
        cyc();

        // Reset asserted during FETCH abandons the transaction.
        request(1'b0, 32'h0000_1000, 32'h0);
        cyc();                                   // LOOKUP
        cpu_req_valid = 1'b0;
        cyc();                                   // FETCH
        check("rst_fetch_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_outputs",
              {25'h0, mem_req, cpu_resp_valid, cpu_req_ready, cc_read_en, cc_write_en,
               cc_alloc_en, cc_cpu_write}, 32'h0);
        check("rst_counters", {20'h0, hit_cnt, miss_cnt, wb_cnt}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        mem_ready = 1'b1;
        cyc();
        check("rst_held_ready", {31'h0, cpu_req_ready}, 32'h0);
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_release_ready", {31'h0, cpu_req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rst_no_resp", {30'h0, cpu_resp_valid, mem_req}, 32'h0);
        end

        // Hit counter saturates at all-ones.
        for (int i = 0; i < 15; i++) begin
            read_hit(32'h0000_0400, 32'h1111_0000 + i);
            cyc();
        end
        check("sat_reach", {28'h0, hit_cnt}, 32'hF);
        read_hit(32'h0000_0400, 32'h2222_2222);
        check("sat_rdata", cpu_rdata, 32'h2222_2222);
        check("sat_hold", {28'h0, hit_cnt}, 32'hF);
        check("sat_miss_cnt", {28'h0, miss_cnt}, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
